tiny16_loader: RTL and testbench

Serial program loader sitting directly upstream of the tiny16 core and its word memory. It consumes a byte stream from the UART receiver, assembles 16-bit words, and writes them into program memory from a base address. It holds the CPU in reset until a complete, valid image has landed, replacing hierarchical memory preload with a real boot path.

---
 rtl/tiny16_pkg.sv | 21 ++
 rtl/tiny16_loader_timeout.sv | 39 +++
 rtl/tiny16_loader.sv | 146 ++++++++++++++
 tb/tb_tiny16_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny16_pkg.sv
// tiny16 loader shared definitions: state encoding, sync byte, word width.
// TINY16_LOADER_CHECKSUM_EN adds the trailing checksum state.
package tiny16_pkg;

   localparam int         WORD_W      = 16;
   localparam logic [7:0] LOADER_SYNC = 8'h55;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA_HI,
      ST_DATA_LO,
`ifdef TINY16_LOADER_CHECKSUM_EN
      ST_CHK,
`endif
      ST_DONE,
      ST_ERROR
   } loader_state_t;

endpackage

// File: rtl/tiny16_loader_timeout.sv
// Inter-byte watchdog: reloads on every received byte, counts idle cycles
// while enabled, flags the cycle in which the idle budget is used up.
// CYCLES == 0 ties the flag off.
module tiny16_loader_timeout #(
   parameter int unsigned CYCLES = 1000000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_kick,
   output logic o_expired
);

   generate
      if (CYCLES == 0) begin : g_off
         logic w_unused;
         assign w_unused  = &{1'b0, i_clk, i_rst, i_en, i_kick};
         assign o_expired = 1'b0;
      end else begin : g_on
         localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
         localparam logic [CW-1:0] RELOAD = CW'(CYCLES - 1);
         logic [CW-1:0] r_cnt;

         // Reload on a byte, otherwise count down idle cycles while armed
         always_ff @(posedge i_clk) begin
            if (i_rst)
               r_cnt <= '0;
            else if (i_kick)
               r_cnt <= RELOAD;
            else if (i_en && (r_cnt != '0))
               r_cnt <= r_cnt - CW'(1);
         end

         // Expired on the CYCLES-th consecutive idle cycle
         assign o_expired = i_en && !i_kick && (r_cnt == '0);
      end
   endgenerate

endmodule

// File: rtl/tiny16_loader.sv
// Serial boot loader for tiny16: sync 0x55, 16-bit word count, N words
// (high byte first), written to program memory from BASE_ADDR. Holds the
// core in reset until the image is complete.
// TINY16_LOADER_CHECKSUM_EN: require a trailing 8-bit sum of the data bytes.
module tiny16_loader
   import tiny16_pkg::*;
#(
   parameter int unsigned          ADDR_W         = 16,
   parameter logic [ADDR_W-1:0]    BASE_ADDR      = '0,
   parameter int unsigned          MEM_DEPTH      = 256,
   parameter int unsigned          TIMEOUT_CYCLES = 1000000
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_rx_valid,
   input  logic [7:0]          i_rx_data,
   output logic                o_mem_we,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [WORD_W-1:0]   o_mem_data,
   output logic                o_cpu_rst,
   output logic                o_done,
   output logic                o_err
);

   localparam logic [16:0] DEPTH17 = 17'(MEM_DEPTH);
`ifdef TINY16_LOADER_CHECKSUM_EN
   localparam loader_state_t ST_END = ST_CHK;
`else
   localparam loader_state_t ST_END = ST_DONE;
`endif

   loader_state_t      r_state, w_next;
   logic [7:0]         r_len_hi, r_hi;
   logic [15:0]        r_len, r_idx, w_len;
   logic               w_we, w_sync, w_last, w_to_en, w_to_exp;
   logic               r_mem_we, r_cpu_rst, r_done, r_err;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [WORD_W-1:0]  r_mem_data;
`ifdef TINY16_LOADER_CHECKSUM_EN
   logic [7:0]         r_sum;
`endif

   assign w_to_en = !(r_state inside {ST_IDLE, ST_DONE, ST_ERROR});

   tiny16_loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (w_to_en),
      .i_kick    (i_rx_valid),
      .o_expired (w_to_exp)
   );

   // Next state and per-byte control
   always_comb begin
      w_next = r_state;
      w_we   = 1'b0;
      w_sync = 1'b0;
      w_len  = {r_len_hi, i_rx_data};
      w_last = (r_idx == r_len - 16'd1);
      case (r_state)
         ST_IDLE:
            if (i_rx_valid && i_rx_data == LOADER_SYNC) begin
               w_next = ST_LEN_HI;
               w_sync = 1'b1;
            end
         ST_LEN_HI:
            if (i_rx_valid) w_next = ST_LEN_LO;
         ST_LEN_LO:
            if (i_rx_valid) begin
               if ({1'b0, w_len} > DEPTH17) w_next = ST_ERROR;
               else if (w_len == 16'd0)     w_next = ST_END;
               else                         w_next = ST_DATA_HI;
            end
         ST_DATA_HI:
            if (i_rx_valid) w_next = ST_DATA_LO;
         ST_DATA_LO:
            if (i_rx_valid) begin
               w_we   = 1'b1;
               w_next = w_last ? ST_END : ST_DATA_HI;
            end
`ifdef TINY16_LOADER_CHECKSUM_EN
         ST_CHK:
            if (i_rx_valid) w_next = (i_rx_data == r_sum) ? ST_DONE : ST_ERROR;
`endif
         ST_DONE:
            w_next = ST_DONE;
         ST_ERROR:
            if (i_rx_valid && i_rx_data == LOADER_SYNC) begin
               w_next = ST_LEN_HI;
               w_sync = 1'b1;
            end
         default:
            w_next = ST_IDLE;
      endcase
      if (w_to_exp) w_next = ST_ERROR;
   end

   // State, frame datapath and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_len_hi   <= '0;
         r_len      <= '0;
         r_hi       <= '0;
         r_idx      <= '0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= BASE_ADDR;
         r_mem_data <= '0;
         r_cpu_rst  <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
`ifdef TINY16_LOADER_CHECKSUM_EN
         r_sum      <= '0;
`endif
      end else begin
         r_state  <= w_next;
         r_mem_we <= w_we;
         if (w_we) begin
            r_mem_addr <= BASE_ADDR + ADDR_W'(r_idx);
            r_mem_data <= {r_hi, i_rx_data};
         end
         if (w_sync)    r_idx <= '0;
         else if (w_we) r_idx <= r_idx + 16'd1;
         if (i_rx_valid && r_state == ST_LEN_HI)  r_len_hi <= i_rx_data;
         if (i_rx_valid && r_state == ST_LEN_LO)  r_len    <= w_len;
         if (i_rx_valid && r_state == ST_DATA_HI) r_hi     <= i_rx_data;
`ifdef TINY16_LOADER_CHECKSUM_EN
         if (w_sync)
            r_sum <= '0;
         else if (i_rx_valid && (r_state == ST_DATA_HI || r_state == ST_DATA_LO))
            r_sum <= r_sum + i_rx_data;
`endif
         r_done    <= (w_next == ST_DONE);
         r_err     <= (w_next == ST_ERROR);
         r_cpu_rst <= (w_next != ST_DONE);
      end
   end

   assign o_mem_we   = r_mem_we;
   assign o_mem_addr = r_mem_addr;
   assign o_mem_data = r_mem_data;
   assign o_cpu_rst  = r_cpu_rst;
   assign o_done     = r_done;
   assign o_err      = r_err;

endmodule

// File: tb/tb_tiny16_loader.sv
// Bench for tiny16_loader: directed frames plus random byte streams, each
// byte's expected effect derived from the frame layout.
module tb_tiny16_loader;

   localparam logic [15:0] BASE  = 16'h0040;
   localparam int          DEPTH = 256;
   localparam int          TO    = 10;
   localparam int          LOAD  = 0, DONE = 1, ERR = 2;

   logic        i_clk = 1'b0;
   logic        i_rst, i_rx_valid;
   logic [7:0]  i_rx_data;
   logic        o_mem_we, o_cpu_rst, o_done, o_err;
   logic [15:0] o_mem_addr, o_mem_data;

   int n_vec = 0, n_err = 0;

   logic [7:0]  stream[$];
   int          exp_wr[$], exp_st[$];
   logic [15:0] exp_addr[$], exp_data[$];

   always #5 i_clk = ~i_clk;

   tiny16_loader #(
      .ADDR_W(16), .BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
      .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
      .o_cpu_rst(o_cpu_rst), .o_done(o_done), .o_err(o_err)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one input cycle; returns at the following negedge
   task automatic drive(input logic v, input logic [7:0] d);
      i_rx_valid = v;
      i_rx_data  = d;
      @(negedge i_clk);
   endtask

   task automatic check_status(input string tag, input int st);
      check({tag, ".done"},    32'(o_done),    32'(st == DONE));
      check({tag, ".err"},     32'(o_err),     32'(st == ERR));
      check({tag, ".cpu_rst"}, 32'(o_cpu_rst), 32'(st != DONE));
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      drive(1'b0, 8'h00);
      drive(1'b0, 8'h00);
      check("rst.we",   32'(o_mem_we),   32'd0);
      check("rst.addr", 32'(o_mem_addr), 32'(BASE));
      check("rst.data", 32'(o_mem_data), 32'd0);
      check_status("rst", LOAD);
      i_rst = 1'b0;
   endtask

   task automatic push_garbage();
      logic [7:0] b;
      b = 8'($urandom);
      if (b == 8'h55) b = 8'h56;
      stream.push_back(b);
   endtask

   // Frame of n words; over-long lengths send only the header
   task automatic gen_frame(input int n, input bit bad);
      logic [7:0] sum, b;
      sum = 8'h00;
      stream.push_back(8'h55);
      stream.push_back(8'(n >> 8));
      stream.push_back(8'(n));
      if (n > DEPTH) return;
      for (int k = 0; k < 2 * n; k++) begin
         b = 8'($urandom);
         stream.push_back(b);
         sum = sum + b;
      end
`ifdef TINY16_LOADER_CHECKSUM_EN
      stream.push_back(bad ? ~sum : sum);
`else
      if (bad) stream.push_back(sum);
`endif
   endtask

   // Reference: walk the stream frame by frame using byte positions
   task automatic model();
      int p, n, st, hi;
      logic [7:0] sum;
      exp_wr.delete(); exp_st.delete(); exp_addr.delete(); exp_data.delete();
      for (int i = 0; i < stream.size(); i++) begin
         exp_wr.push_back(0); exp_st.push_back(LOAD);
         exp_addr.push_back(16'h0); exp_data.push_back(16'h0);
      end
      st = LOAD;
      p  = 0;
      while (p < stream.size()) begin
         if (st == DONE || stream[p] != 8'h55) begin
            exp_st[p] = st;
            p++;
            continue;
         end
         n = int'({stream[p+1], stream[p+2]});
         if (n > DEPTH) begin
            st = ERR;
            exp_st[p+2] = ERR;
            p += 3;
            continue;
         end
         sum = 8'h00;
         for (int k = 0; k < n; k++) begin
            hi = p + 3 + 2 * k;
            exp_wr[hi+1]   = 1;
            exp_addr[hi+1] = BASE + 16'(k);
            exp_data[hi+1] = {stream[hi], stream[hi+1]};
            sum = sum + stream[hi] + stream[hi+1];
         end
         p = p + 3 + 2 * n;
`ifdef TINY16_LOADER_CHECKSUM_EN
         st = (stream[p] == sum) ? DONE : ERR;
         exp_st[p] = st;
         p++;
`else
         st = DONE;
         exp_st[p-1] = DONE;
`endif
      end
   endtask

   task automatic run_stream(input bit b2b);
      int gap;
      model();
      for (int i = 0; i < stream.size(); i++) begin
         drive(1'b1, stream[i]);
         check("we", 32'(o_mem_we), 32'(exp_wr[i]));
         if (exp_wr[i] != 0) begin
            check("addr", 32'(o_mem_addr), 32'(exp_addr[i]));
            check("data", 32'(o_mem_data), 32'(exp_data[i]));
         end
         check_status("byte", exp_st[i]);
         gap = b2b ? 0 : int'($urandom_range(0, 3));
         repeat (gap) begin
            drive(1'b0, 8'h00);
            check("idle.we", 32'(o_mem_we), 32'd0);
            check_status("idle", exp_st[i]);
         end
      end
      drive(1'b0, 8'h00);
      check("tail.we", 32'(o_mem_we), 32'd0);
   endtask

   initial begin
      int nf;
      i_rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00;
      @(negedge i_clk);

      // Basic two-word load, then stray bytes (incl. sync) after done
      do_reset();
      stream = '{8'h55, 8'h00, 8'h02, 8'h15, 8'h01, 8'h17, 8'h02};
`ifdef TINY16_LOADER_CHECKSUM_EN
      stream.push_back(8'h2D);
`endif
      stream.push_back(8'h55); stream.push_back(8'h00); stream.push_back(8'h01);
      stream.push_back(8'h99); stream.push_back(8'h99);
      run_stream(1'b0);

      // Zero length
      do_reset();
      stream = '{8'h55, 8'h00, 8'h00};
`ifdef TINY16_LOADER_CHECKSUM_EN
      stream.push_back(8'h00);
`endif
      run_stream(1'b1);

      // Length overflow by one, then the largest legal frame
      do_reset();
      stream = '{8'h55, 8'h01, 8'h01};
      gen_frame(DEPTH, 1'b0);
      run_stream(1'b1);

`ifdef TINY16_LOADER_CHECKSUM_EN
      // Checksum mismatch, then recovery
      do_reset();
      stream = '{8'h55, 8'h00, 8'h01, 8'h12, 8'h34, 8'h00,
                 8'h55, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'h78};
      run_stream(1'b0);
`endif

      // Timeout: err exactly after TO idle cycles mid-frame
      do_reset();
      drive(1'b1, 8'h55);
      drive(1'b1, 8'h00);
      for (int c = 1; c <= TO; c++) begin
         drive(1'b0, 8'h00);
         check("to.err",     32'(o_err),     32'(c == TO));
         check("to.cpu_rst", 32'(o_cpu_rst), 32'd1);
      end
      stream = '{8'h55, 8'h00, 8'h01, 8'hAB, 8'hCD};
`ifdef TINY16_LOADER_CHECKSUM_EN
      stream.push_back(8'h78);
`endif
      run_stream(1'b0);

      // Back-to-back bytes with reset landing on the low byte
      do_reset();
      drive(1'b1, 8'h55); drive(1'b1, 8'h00); drive(1'b1, 8'h02); drive(1'b1, 8'h15);
      check("b2b.we", 32'(o_mem_we), 32'd0);
      i_rst = 1'b1;
      drive(1'b1, 8'h01);
      check("midrst.we",   32'(o_mem_we),   32'd0);
      check("midrst.addr", 32'(o_mem_addr), 32'(BASE));
      check_status("midrst", LOAD);
      i_rst = 1'b0;
      drive(1'b0, 8'h00);
      check("postrst.we", 32'(o_mem_we), 32'd0);
      check_status("postrst", LOAD);
      stream.delete();
      gen_frame(3, 1'b0);
      run_stream(1'b1);

      // Random streams: garbage, bad frames, good frame, trailing bytes
      for (int t = 0; t < 30; t++) begin
         do_reset();
         stream.delete();
         repeat ($urandom_range(0, 2)) push_garbage();
         nf = int'($urandom_range(1, 3));
         for (int f = 0; f < nf; f++) begin
            if (f == nf - 1)
               gen_frame(int'($urandom_range(0, 6)), 1'b0);
            else begin
               if ($urandom_range(0, 1) == 0)
                  gen_frame(int'($urandom_range(DEPTH + 1, DEPTH + 40)), 1'b0);
               else
                  gen_frame(int'($urandom_range(1, 4)), 1'b1);
               repeat ($urandom_range(0, 1)) push_garbage();
            end
         end
         repeat ($urandom_range(0, 3)) stream.push_back(8'($urandom));
         run_stream(1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
